// File: rtl/axi_tx.sv
// axi_tx: beat FIFO feeding an AXI-Stream master, with frame and byte counting.
// Build option AXI_TX_PAD_EN: pads short frames to a 60-byte minimum.
module axi_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             tdata_in,
  input  logic [$clog2(DATA_WIDTH/8+1)-1:0] idx_in,
  input  logic                              data_valid_in,
  input  logic                              last_flag_in,
  output logic                              tx_ready,
  output logic                              tvalid,
  output logic [DATA_WIDTH-1:0]             tdata,
  output logic [DATA_WIDTH/8-1:0]           tkeep,
  output logic                              tlast,
  input  logic                              tready,
  output logic [15:0]                       tx_frames,
  output logic                              proto_err
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef AXI_TX_PAD_EN
  localparam logic [16:0] MIN_BYTES = 17'd60;
`endif

  // state  | meaning
  // IDLE   | FIFO empty, no frame in flight
  // DATA   | presenting FIFO entries
  // PAD    | emitting zero fill up to the minimum frame length
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1
`ifdef AXI_TX_PAD_EN
    , S_PAD = 2'd2
`endif
  } state_t;

  function automatic logic [16:0] popcnt(input logic [KW-1:0] k);
    logic [16:0] n;
    n = '0;
    for (int i = 0; i < KW; i++) n = n + 17'(k[i]);
    return n;
  endfunction

  function automatic logic [KW-1:0] low_mask(input logic [16:0] n);
    logic [KW-1:0] m;
    m = '0;
    for (int i = 0; i < KW; i++) m[i] = (17'(i) < n);
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [KW-1:0]         r_mem_keep [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  state_t                r_state;
  logic [15:0]           r_byte_cnt;
  logic [15:0]           r_frames;
  logic                  r_proto_err;

  state_t                w_state_nxt;
  logic                  w_full, w_empty, w_accept, w_push, w_pop, w_fire, w_valid;
  logic                  w_tag_last, w_tag_ok, w_proto_set;
  logic [KW-1:0]         w_in_keep;
  logic [CW-1:0]         w_cnt_nxt;
  logic [AW-1:0]         w_last_idx;
  logic [DATA_WIDTH-1:0] w_head_data, w_out_data;
  logic [KW-1:0]         w_head_keep, w_out_keep;
  logic                  w_head_last, w_out_last;
  logic [16:0]           w_byte_sum;
`ifdef AXI_TX_PAD_EN
  logic [16:0]           w_end_cnt, w_fill_cnt, w_pad_rem;
  logic                  w_pad_start;
`endif

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_accept   = data_valid_in && tx_ready;
  assign w_push     = w_accept && (idx_in != '0);
  assign w_in_keep  = low_mask(17'(idx_in));
  assign w_last_idx = r_wr_ptr - AW'(1);
  assign w_fire     = w_valid && tready;
  assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);

  // A zero-length last beat closes the frame on the newest entry, unless that
  // entry has already left (or is leaving this cycle).
  assign w_tag_last  = w_accept && (idx_in == '0) && last_flag_in;
  assign w_tag_ok    = w_tag_last && !w_empty && !((r_count == CW'(1)) && w_pop);
  assign w_proto_set = (w_tag_last && !w_tag_ok) ||
                       (w_accept && !last_flag_in && (17'(idx_in) < 17'(KW)));

  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_keep = r_mem_keep[r_rd_ptr];
  assign w_head_last = r_mem_last[r_rd_ptr];

`ifdef AXI_TX_PAD_EN
  assign w_pop   = w_fire && (r_state != S_PAD);
  assign w_valid = !rst && (!w_empty || (r_state == S_PAD));
`else
  assign w_pop   = w_fire;
  assign w_valid = !rst && !w_empty;
`endif

  always_comb begin
    w_out_data = w_head_data;
    w_out_keep = w_head_keep;
    w_out_last = w_head_last;
`ifdef AXI_TX_PAD_EN
    w_pad_start = 1'b0;
    w_end_cnt   = {1'b0, r_byte_cnt} + popcnt(w_head_keep);
    w_fill_cnt  = {1'b0, r_byte_cnt} + 17'(KW);
    w_pad_rem   = MIN_BYTES - {1'b0, r_byte_cnt};
    if (r_state == S_PAD) begin
      w_out_data = '0;
      w_out_keep = low_mask(w_pad_rem);
      w_out_last = (w_pad_rem <= 17'(KW));
    end else if (w_head_last && (w_end_cnt < MIN_BYTES)) begin
      // short final beat: widen to a full beat with unused bytes zeroed
      for (int b = 0; b < KW; b++)
        w_out_data[8*b +: 8] = w_head_keep[b] ? w_head_data[8*b +: 8] : 8'h00;
      w_out_keep  = '1;
      w_out_last  = (w_fill_cnt >= MIN_BYTES);
      w_pad_start = !w_out_last;
    end
`endif
  end

  assign w_byte_sum = {1'b0, r_byte_cnt} + popcnt(w_out_keep);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DATA: begin
        if (w_fire && w_out_last && (w_cnt_nxt == '0)) w_state_nxt = S_IDLE;
        else if (!w_empty)                             w_state_nxt = S_DATA;
`ifdef AXI_TX_PAD_EN
        if (w_fire && w_pad_start) w_state_nxt = S_PAD;
`endif
      end
`ifdef AXI_TX_PAD_EN
      S_PAD: begin
        if (w_fire && w_out_last) w_state_nxt = (w_cnt_nxt == '0) ? S_IDLE : S_DATA;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_frames    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (w_proto_set) r_proto_err <= 1'b1;
      if (w_fire) begin
        if (w_out_last) begin
          r_byte_cnt <= '0;
          r_frames   <= r_frames + 16'd1;
        end else begin
          r_byte_cnt <= w_byte_sum[16] ? 16'hFFFF : w_byte_sum[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= tdata_in;
      r_mem_keep[r_wr_ptr] <= w_in_keep;
      r_mem_last[r_wr_ptr] <= last_flag_in;
    end
    if (w_tag_ok) r_mem_last[w_last_idx] <= 1'b1;
  end

  assign tx_ready  = !rst && !w_full;
  assign tvalid    = w_valid;
  assign tdata     = w_valid ? w_out_data : '0;
  assign tkeep     = w_valid ? w_out_keep : '0;
  assign tlast     = w_valid && w_out_last;
  assign tx_frames = rst ? 16'd0 : r_frames;
  assign proto_err = !rst && r_proto_err;

endmodule

// File: tb/tb_axi_tx.sv
// Directed self-checking bench for axi_tx (DATA_WIDTH=64, FIFO_DEPTH=4).
// Expectations follow the AXI_TX_PAD_EN build setting.
module tb_axi_tx;
  logic        clk;
  logic        rst;
  logic [63:0] tdata_in;
  logic [3:0]  idx_in;
  logic        data_valid_in;
  logic        last_flag_in;
  logic        tx_ready;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tready;
  logic [15:0] tx_frames;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AXI_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  axi_tx #(.DATA_WIDTH(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tdata_in(tdata_in), .idx_in(idx_in),
    .data_valid_in(data_valid_in), .last_flag_in(last_flag_in),
    .tx_ready(tx_ready), .tvalid(tvalid), .tdata(tdata), .tkeep(tkeep),
    .tlast(tlast), .tready(tready), .tx_frames(tx_frames), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [63:0] d, input logic [3:0] idx, input logic l);
    data_valid_in = v;
    tdata_in      = d;
    idx_in        = idx;
    last_flag_in  = l;
  endtask

  task automatic drain(output int beats);
    beats  = 0;
    tready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (tvalid) beats++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tready = 1'b0; set_in(0, '0, '0, 0);
    tick(); tick();
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0h expected 0", tvalid); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready: got %0h expected 0", tx_ready); end
    n_checks++; if (tdata !== 64'h0) begin n_fail++; $display("FAIL reset_tdata: got %0h expected 0", tdata); end
    n_checks++; if (tkeep !== 8'h0) begin n_fail++; $display("FAIL reset_tkeep: got %0h expected 0", tkeep); end
    n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %0h expected 0", tlast); end
    n_checks++; if (tx_frames !== 16'h0) begin n_fail++; $display("FAIL reset_frames: got %0h expected 0", tx_frames); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %0h expected 0", proto_err); end
    rst = 1'b0;
    #1;
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0h expected 1", tx_ready); end
  endtask

  task automatic test_single();
    int beats;
    tready = 1'b1;
    set_in(1, 64'h0807060504030201, 4'd8, 1);
    tick();
    set_in(0, '0, '0, 0);
    n_checks++; if (tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid: got %0h expected 1", tvalid); end
    n_checks++; if (tkeep !== 8'hFF) begin n_fail++; $display("FAIL single_tkeep: got %0h expected ff", tkeep); end
    n_checks++; if (tlast !== !PAD) begin n_fail++; $display("FAIL single_tlast: got %0h expected %0h", tlast, !PAD); end
    n_checks++; if (tdata !== 64'h0807060504030201) begin n_fail++; $display("FAIL single_tdata: got %0h expected 0807060504030201", tdata); end
    drain(beats);
    n_checks++; if (beats != (PAD ? 8 : 1)) begin n_fail++; $display("FAIL single_beats: got %0d expected %0d", beats, PAD ? 8 : 1); end
    n_checks++; if (tx_frames !== 16'd1) begin n_fail++; $display("FAIL single_frames: got %0d expected 1", tx_frames); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d [5];
    logic [63:0] exp;
    logic        acc;
    int          got;
    for (int i = 0; i < 5; i++) d[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (tx_ready !== 1'(i < 4)) begin n_fail++; $display("FAIL b2b_ready_%0d: got %0h expected %0h", i, tx_ready, i < 4); end
      if (i > 0) begin
        n_checks++; if (tdata !== d[0]) begin n_fail++; $display("FAIL b2b_stall_data_%0d: got %0h expected %0h", i, tdata, d[0]); end
      end
      set_in(1, d[i], 4'd8, i == 4);
      tick();
    end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %0h expected 0", tx_ready); end
    n_checks++; if (tdata !== d[0]) begin n_fail++; $display("FAIL b2b_full_data: got %0h expected %0h", tdata, d[0]); end
    tready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (tvalid) begin
        exp = (got < 5) ? d[got] : 64'h0;
        n_checks++; if (tdata !== exp) begin n_fail++; $display("FAIL b2b_data_beat%0d: got %0h expected %0h", got, tdata, exp); end
        got++;
      end
      acc = data_valid_in && tx_ready;
      tick();
      if (acc) set_in(0, '0, '0, 0);
    end
    n_checks++; if (got != (PAD ? 8 : 5)) begin n_fail++; $display("FAIL b2b_beats: got %0d expected %0d", got, PAD ? 8 : 5); end
    n_checks++; if (tx_frames !== 16'd2) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 2", tx_frames); end
  endtask

  task automatic test_short_frame();
    logic [63:0] ed [8];
    logic [7:0]  ek [8];
    logic        el [8];
    int          nexp, got;
    for (int i = 0; i < 8; i++) begin ed[i] = '0; ek[i] = 8'hFF; el[i] = 1'b0; end
    ed[0] = 64'h2222_2222_2222_2222;
`ifdef AXI_TX_PAD_EN
    ed[1] = 64'h0000_6655_4433_2211;
    ek[7] = 8'h0F; el[7] = 1'b1;
    nexp  = 8;
`else
    ed[1] = 64'hEEEE_6655_4433_2211;
    ek[1] = 8'h3F; el[1] = 1'b1;
    nexp  = 2;
`endif
    tready = 1'b1;
    set_in(1, 64'h2222_2222_2222_2222, 4'd8, 0);
    tick();
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) set_in(1, 64'hEEEE_6655_4433_2211, 4'd6, 1);
      else        set_in(0, '0, '0, 0);
      if (tvalid) begin
        if (got < nexp) begin
          n_checks++; if (tdata !== ed[got]) begin n_fail++; $display("FAIL short_data_beat%0d: got %0h expected %0h", got, tdata, ed[got]); end
          n_checks++; if (tkeep !== ek[got]) begin n_fail++; $display("FAIL short_keep_beat%0d: got %0h expected %0h", got, tkeep, ek[got]); end
          n_checks++; if (tlast !== el[got]) begin n_fail++; $display("FAIL short_last_beat%0d: got %0h expected %0h", got, tlast, el[got]); end
        end else begin
          n_checks++; n_fail++; $display("FAIL short_extra_beat%0d: got tdata %0h expected no beat", got, tdata);
        end
        got++;
      end
      tick();
    end
    n_checks++; if (got != nexp) begin n_fail++; $display("FAIL short_beats: got %0d expected %0d", got, nexp); end
    n_checks++; if (tx_frames !== 16'd3) begin n_fail++; $display("FAIL short_frames: got %0d expected 3", tx_frames); end
  endtask

  task automatic test_proto_err();
    int beats;
    tready = 1'b0;
    set_in(1, 64'h7766_5544_33CC_BBAA, 4'd3, 0);
    tick();
    set_in(0, '0, '0, 0);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %0h expected 1", proto_err); end
    n_checks++; if (tvalid !== 1'b1) begin n_fail++; $display("FAIL proto_fwd_valid: got %0h expected 1", tvalid); end
    n_checks++; if (tkeep !== 8'h07) begin n_fail++; $display("FAIL proto_fwd_keep: got %0h expected 07", tkeep); end
    n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL proto_fwd_last: got %0h expected 0", tlast); end
    n_checks++; if (tdata !== 64'h7766_5544_33CC_BBAA) begin n_fail++; $display("FAIL proto_fwd_data: got %0h expected 776655443 3ccbbaa", tdata); end
    set_in(1, 64'h0000_0000_0000_DEAD, 4'd0, 1);
    tick();
    set_in(0, '0, '0, 0);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %0h expected 1", proto_err); end
    n_checks++; if (tlast !== !PAD) begin n_fail++; $display("FAIL proto_tag_last: got %0h expected %0h", tlast, !PAD); end
    n_checks++; if (tkeep !== (PAD ? 8'hFF : 8'h07)) begin n_fail++; $display("FAIL proto_tag_keep: got %0h expected %0h", tkeep, PAD ? 8'hFF : 8'h07); end
    n_checks++; if (tdata !== (PAD ? 64'h0000_0000_00CC_BBAA : 64'h7766_5544_33CC_BBAA)) begin n_fail++; $display("FAIL proto_tag_data: got %0h", tdata); end
    drain(beats);
    n_checks++; if (beats != (PAD ? 8 : 1)) begin n_fail++; $display("FAIL proto_beats: got %0d expected %0d", beats, PAD ? 8 : 1); end
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_hold: got %0h expected 1", proto_err); end
    n_checks++; if (tx_frames !== 16'd4) begin n_fail++; $display("FAIL proto_frames: got %0d expected 4", tx_frames); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp;
    int          got;
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 64'h3131_3131_3131_3131 + 64'(i), 4'd8, 0);
      tick();
    end
    set_in(0, '0, '0, 0);
    rst = 1'b1;
    #1;
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_rst_valid: got %0h expected 0", tvalid); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_rst_ready: got %0h expected 0", tx_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0h expected 0", tvalid); end
    n_checks++; if (tx_frames !== 16'd0) begin n_fail++; $display("FAIL rstmid_frames: got %0d expected 0", tx_frames); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %0h expected 1", tx_ready); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_proto_clr: got %0h expected 0", proto_err); end
    tready = 1'b1;
    set_in(1, 64'h4141_4141_4141_4141, 4'd8, 0);
    tick();
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) set_in(1, 64'h4242_4242_4242_4242, 4'd8, 1);
      else        set_in(0, '0, '0, 0);
      if (tvalid) begin
        exp = (got == 0) ? 64'h4141_4141_4141_4141 : (got == 1) ? 64'h4242_4242_4242_4242 : 64'h0;
        n_checks++; if (tdata !== exp) begin n_fail++; $display("FAIL rstmid_data_beat%0d: got %0h expected %0h", got, tdata, exp); end
        if (got == 1) begin
          n_checks++; if (tlast !== !PAD) begin n_fail++; $display("FAIL rstmid_last: got %0h expected %0h", tlast, !PAD); end
        end
        got++;
      end
      tick();
    end
    n_checks++; if (got != (PAD ? 8 : 2)) begin n_fail++; $display("FAIL rstmid_beats: got %0d expected %0d", got, PAD ? 8 : 2); end
    n_checks++; if (tx_frames !== 16'd1) begin n_fail++; $display("FAIL rstmid_new_frames: got %0d expected 1", tx_frames); end
    set_in(1, '0, 4'd0, 1);
    tick();
    set_in(0, '0, '0, 0);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL orphan_last_err: got %0h expected 1", proto_err); end
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL orphan_last_valid: got %0h expected 0", tvalid); end
  endtask

  task automatic test_frame_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tready = 1'b1;
`ifndef AXI_TX_PAD_EN
    set_in(1, 64'h5A5A_5A5A_5A5A_5A5A, 4'd8, 1);
    for (int i = 0; i < 65535; i++) tick();
    set_in(0, '0, '0, 0);
    repeat (4) tick();
    n_checks++; if (tx_frames !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %0h expected ffff", tx_frames); end
    set_in(1, 64'h5A5A_5A5A_5A5A_5A5A, 4'd8, 1);
    tick();
    set_in(0, '0, '0, 0);
    repeat (4) tick();
    n_checks++; if (tx_frames !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %0h expected 0", tx_frames); end
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got %0h expected 0", tvalid); end
`else
    set_in(1, 64'h5A5A_5A5A_5A5A_5A5A, 4'd8, 1);
    repeat (3) tick();
    set_in(0, '0, '0, 0);
    repeat (40) tick();
    n_checks++; if (tx_frames !== 16'd3) begin n_fail++; $display("FAIL pad_frames: got %0d expected 3", tx_frames); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    tready = 1'b0;
    set_in(0, '0, '0, 0);
    test_reset();
    test_single();
    test_back_to_back();
    test_short_frame();
    test_proto_err();
    test_reset_mid();
    test_frame_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end
endmodule
